// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter family: default width and the
// next-q selection encoding.
package counter_pkg;

  localparam int DATA_WIDTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    HOLD,
    LOAD,
    INC,
    WRAP,
    SAT
  } next_sel_e;

endpackage : counter_pkg

// File: rtl/count_cmp.sv
// Unsigned comparator of the current count against the runtime limit.
module count_cmp
  import counter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic [DATA_WIDTH-1:0] q,
  input  logic [DATA_WIDTH-1:0] limit,
  output logic                  eq,
  output logic                  ge
);

  assign eq = (q == limit);
  assign ge = (q >= limit);

endmodule : count_cmp

// File: rtl/upcounter.sv
// Loadable up counter with runtime modulus (0..limit), wrap pulse and sticky ovf.
// Define UPCOUNTER_SATURATE_EN to clamp at limit instead of wrapping to 0.
module upcounter
  import counter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic                  count_en,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic [DATA_WIDTH-1:0] limit,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  tc,
  output logic                  wrap,
  output logic                  ovf
);

  logic      at_limit;
  logic      past_limit;
  next_sel_e sel;

  count_cmp #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
    .q     (q),
    .limit (limit),
    .eq    (at_limit),
    .ge    (past_limit)
  );

  assign tc = at_limit;

  // Reset is handled in the register itself, so sel only covers load/count/hold.
  always_comb begin
    sel = HOLD;
    if (load_en) begin
      sel = LOAD;
    end else if (count_en) begin
      if (!past_limit) begin
        sel = INC;
      end else begin
`ifdef UPCOUNTER_SATURATE_EN
        sel = SAT;
`else
        sel = WRAP;
`endif
      end
    end
  end

  // q+1 cannot overflow: INC is only chosen while q < limit <= 2^W-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      unique case (sel)
        LOAD: begin
          q    <= d;
          wrap <= 1'b0;
          ovf  <= 1'b0;
        end
        INC: begin
          q    <= q + DATA_WIDTH'(1);
          wrap <= 1'b0;
        end
        WRAP: begin
          q    <= '0;
          wrap <= 1'b1;
          ovf  <= 1'b1;
        end
        SAT: begin
          q    <= limit;
          wrap <= 1'b0;
          ovf  <= 1'b1;
        end
        default: begin
          wrap <= 1'b0;
        end
      endcase
    end
  end

endmodule : upcounter
